// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU engine that owns the HI/LO pair.
// A multiply runs 32 shift-add steps and a divide runs 32 restoring
// shift-subtract steps, both on operand magnitudes. The sign is applied when
// the result is written to HI/LO. MTHI/MTLO writes are accepted only while idle.
//
// Optional feature macro: MULTDIV_FAST_MULT_EN. When it is defined, MULT/MULTU
// finish in a single cycle using an array multiply and never raise busy.
// Divide timing is the same in both builds.
//
// Handshake: start is a request that is taken on a rising edge only when busy
// is low, and no request is queued. done is a registered one-cycle pulse on
// the cycle in which HI/LO show a new result. The control unit holds every
// HI/LO access while busy is high.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        dbg_state
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e      state_q;
  logic [5:0]  cnt_q;
  logic        is_div_q;
  logic        neg_res_q;   // product sign or quotient sign
  logic        neg_rem_q;   // remainder takes the sign of the dividend
  logic [31:0] opa_q;       // raw dividend, returned in HI on divide by zero
  logic [31:0] mag_a_q;     // multiplicand magnitude
  logic [31:0] mag_b_q;     // divisor magnitude
  logic [63:0] p_q;         // product, or {remainder, quotient/dividend}
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        done_q;

  logic [5:0]  cnt_d;
  logic [63:0] p_d;
  logic [32:0] mul_sum;
  logic [32:0] div_sh;
  logic [32:0] div_sub;
  logic        div_ge;
  logic [63:0] prod_fix;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        a_neg_in;
  logic        b_neg_in;
  logic [31:0] mag_a_in;
  logic [31:0] mag_b_in;
  logic        fast_take;
  logic [63:0] fast_prod;

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = (state_q == RUN);
  assign done      = done_q;
  assign dbg_state = state_q;

  // Operand signs and magnitudes for the operation being launched.
  always_comb begin
    a_neg_in = ~op[0] & opa[31];
    b_neg_in = ~op[0] & opb[31];
    mag_a_in = a_neg_in ? (32'd0 - opa) : opa;
    mag_b_in = b_neg_in ? (32'd0 - opb) : opb;
  end

`ifdef MULTDIV_FAST_MULT_EN
  // Single-cycle multiply. The low 64 bits of the extended product are exact
  // for both the signed and the unsigned form.
  always_comb begin
    fast_take = ~op[1];
    fast_prod = {(op[0] ? 32'd0 : {32{opa[31]}}), opa} *
                {(op[0] ? 32'd0 : {32{opb[31]}}), opb};
  end
`else
  // Multiplies also use the iterative path.
  always_comb begin
    fast_take = 1'b0;
    fast_prod = 64'd0;
  end
`endif

  // One iteration step, then the sign fix-up applied when the result is written.
  always_comb begin
    cnt_d    = cnt_q + 6'd1;
    mul_sum  = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, mag_a_q} : 33'd0);
    div_sh   = {p_q[63:32], p_q[31]};
    div_sub  = div_sh - {1'b0, mag_b_q};
    div_ge   = (div_sh >= {1'b0, mag_b_q});
    if (is_div_q) begin
      p_d = {(div_ge ? div_sub[31:0] : div_sh[31:0]), p_q[30:0], div_ge};
    end else begin
      p_d = {mul_sum, p_q[31:1]};
    end
    prod_fix = neg_res_q ? (64'd0 - p_d) : p_d;
    if (!is_div_q) begin
      res_hi = prod_fix[63:32];
      res_lo = prod_fix[31:0];
    end else if (mag_b_q == 32'd0) begin
      res_hi = opa_q;
      res_lo = 32'hFFFF_FFFF;
    end else begin
      res_hi = neg_rem_q ? (32'd0 - p_d[63:32]) : p_d[63:32];
      res_lo = neg_res_q ? (32'd0 - p_d[31:0]) : p_d[31:0];
    end
  end

  // Control FSM plus the HI/LO, datapath and done registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 6'd0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      opa_q     <= 32'd0;
      mag_a_q   <= 32'd0;
      mag_b_q   <= 32'd0;
      p_q       <= 64'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && fast_take) begin
            hi_q   <= fast_prod[63:32];
            lo_q   <= fast_prod[31:0];
            done_q <= 1'b1;
          end else if (start) begin
            state_q   <= RUN;
            cnt_q     <= 6'd0;
            is_div_q  <= op[1];
            neg_res_q <= a_neg_in ^ b_neg_in;
            neg_rem_q <= a_neg_in;
            opa_q     <= opa;
            mag_a_q   <= mag_a_in;
            mag_b_q   <= mag_b_in;
            p_q       <= {32'd0, (op[1] ? mag_a_in : mag_b_in)};
          end else begin
            if (hi_we) hi_q <= wdata;
            if (lo_we) lo_q <= wdata;
          end
        end
        RUN: begin
          p_q   <= p_d;
          cnt_q <= cnt_d;
          if (cnt_d == 6'd32) begin
            hi_q    <= res_hi;
            lo_q    <= res_lo;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        dbg_state;

  int n_tests  = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;

  logic [63:0] exp_q[$];
  int          lat_q[$];

  mult_div_unit dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .opa       (opa),
    .opb       (opb),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .wdata     (wdata),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference {HI,LO} computed with the simulator's own arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int     ia, ib, q, r;
    longint la, lb;
    logic [63:0] ua, ub;
    ia = a;
    ib = b;
    case (o)
      2'b00: begin
        la = ia;
        lb = ib;
        return 64'(la * lb);
      end
      2'b01: begin
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (o == 2'b11) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = ia / ib;
        r = ia % ib;
        return {32'(r), 32'(q)};
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] o);
`ifdef MULTDIV_FAST_MULT_EN
    return o[1] ? 33 : 1;
`else
    return 33;
`endif
  endfunction

  function automatic logic exp_busy_after(input logic [1:0] o);
`ifdef MULTDIV_FAST_MULT_EN
    return o[1];
`else
    return 1'b1;
`endif
  endfunction

  // Monitor: every done pops one expected result and its expected cycle.
  always @(negedge clk) begin
    logic [63:0] e;
    int          l;
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check_eq("spurious_done", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        check_eq("hi", {32'd0, hi}, {32'd0, e[63:32]});
        check_eq("lo", {32'd0, lo}, {32'd0, e[31:0]});
        check_eq("done_cycle", 64'(cyc), 64'(l));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge while busy is low; returns at the negedge after acceptance.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    opa   = a;
    opb   = b;
    exp_q.push_back(model(o, a, b));
    lat_q.push_back(cyc + exp_lat(o));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0 || busy) begin
      check_eq("drain_timeout", 64'd1, 64'd0);
      exp_q.delete();
      lat_q.delete();
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    issue(o, a, b);
    check_eq("busy_after_start", {63'd0, busy}, {63'd0, exp_busy_after(o)});
    drain();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] hi_prev;
    logic [31:0] lo_prev;
    int          d0;
    int          k;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    reset = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    opa   = 32'd0;
    opb   = 32'd0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wdata = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_eq("rst_hi", {32'd0, hi}, 64'd0);
    check_eq("rst_lo", {32'd0, lo}, 64'd0);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    check_eq("rst_state", {63'd0, dbg_state}, 64'd0);

    // Directed arithmetic cases.
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    run_op(2'b11, 32'd100, 32'd0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'b10, 32'hFFFF_FFFB, 32'd0);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000);
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE);

    // start and MTHI during an operation are both ignored.
    hi_prev = hi;
    d0      = done_cnt;
    issue(2'b11, 32'd10, 32'd3);
    repeat (5) @(negedge clk);
    start = 1'b1;
    op    = 2'b01;
    opa   = 32'd5;
    opb   = 32'd5;
    hi_we = 1'b1;
    wdata = 32'h0000_1234;
    @(negedge clk);
    start = 1'b0;
    hi_we = 1'b0;
    check_eq("busy_mid_op", {63'd0, busy}, 64'd1);
    check_eq("hold_hi_mid_op", {32'd0, hi}, {32'd0, hi_prev});
    drain();
    repeat (40) @(negedge clk);
    check_eq("single_done", 64'(done_cnt - d0), 64'd1);

    // MTHI / MTLO while idle.
    hi_we = 1'b1;
    wdata = 32'hA5A5_0F0F;
    @(negedge clk);
    hi_we = 1'b0;
    check_eq("mthi", {32'd0, hi}, 64'h0000_0000_A5A5_0F0F);
    lo_prev = lo;
    lo_we = 1'b1;
    wdata = 32'h1357_9BDF;
    @(negedge clk);
    lo_we = 1'b0;
    check_eq("mtlo", {32'd0, lo}, 64'h0000_0000_1357_9BDF);
    check_eq("mtlo_keeps_hi", {32'd0, hi}, 64'h0000_0000_A5A5_0F0F);
    check_eq("mthi_old_lo_replaced", 64'(lo != lo_prev || lo_prev == 32'h1357_9BDF), 64'd1);

    // start wins over a simultaneous MTHI/MTLO.
    hi_prev = hi;
    lo_prev = lo;
    hi_we   = 1'b1;
    lo_we   = 1'b1;
    wdata   = 32'hDEAD_BEEF;
    issue(2'b11, 32'd20, 32'd6);
    hi_we = 1'b0;
    lo_we = 1'b0;
    check_eq("start_prio_hi", {32'd0, hi}, {32'd0, hi_prev});
    check_eq("start_prio_lo", {32'd0, lo}, {32'd0, lo_prev});
    drain();

    // Reset 10 cycles into a DIV aborts it with no done.
    issue(2'b10, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("abort_busy", {63'd0, busy}, 64'd0);
    check_eq("abort_hi", {32'd0, hi}, 64'd0);
    check_eq("abort_lo", {32'd0, lo}, 64'd0);
    exp_q.delete();
    lat_q.delete();
    reset = 1'b0;
    d0 = done_cnt;
    repeat (40) @(negedge clk);
    check_eq("abort_no_done", 64'(done_cnt - d0), 64'd0);

    // Back-to-back: a new start in the done cycle is accepted.
    issue(2'b11, 32'd100, 32'd7);
    k = 0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_eq("b2b_done_seen", {63'd0, done}, 64'd1);
    issue(2'b01, 32'd6, 32'd7);
    check_eq("b2b_busy", {63'd0, busy}, {63'd0, exp_busy_after(2'b01)});
    drain();

    // Random operations.
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom();
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom();
      if ($urandom_range(0, 5) == 0) rb = 32'hFFFF_FFFF;
      run_op(ro, ra, rb);
    end

    check_eq("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Overall time bound.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
